// File: rtl/block_check_sched.sv
// Round-robin front end that buffers a NUL-terminated message from one of two
// requesters, replays it into a freshly cleared block checker and returns a tagged verdict.
module block_check_sched #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [7:0] chk_in,
  output logic       chk_reset,
  input  logic       chk_result,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic       resp_ok,
  output logic       resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CLEAR  = 3'd2;
  localparam logic [2:0] S_PLAY   = 3'd3;
  localparam logic [2:0] S_SAMPLE = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              grant_id_q, grant_id_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [7:0]        chk_in_q, chk_in_d;
  logic              chk_reset_q, chk_reset_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic              resp_ok_q, resp_ok_d;
  logic              resp_err_q, resp_err_d;

  logic [7:0]        mem_q [DEPTH];
  logic              wr_en_c;
  logic              in_valid_c;
  logic [7:0]        in_data_c;

  // Next-state logic; registered outputs are derived from the next state so
  // they line up with the state they belong to.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    ptr_d        = ptr_q;
    ovf_d        = ovf_q;
    resp_id_d    = resp_id_q;
    resp_ok_d    = resp_ok_q;
    resp_err_d   = resp_err_q;
    wr_en_c      = 1'b0;
    in_valid_c   = grant_id_q ? req_valid[1] : req_valid[0];
    in_data_c    = grant_id_q ? req_data1 : req_data0;

    case (state_q)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          if (req_valid == 2'b11) grant_id_d = ~last_grant_q;
          else                    grant_id_d = req_valid[1];
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_valid_c) begin
          if (in_data_c == 8'h00) begin
            state_d = S_CLEAR;
          end else if (count_q < CNT_W'(DEPTH)) begin
            wr_en_c = 1'b1;
            count_d = count_q + CNT_W'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        ptr_d     = '0;
        resp_id_d = grant_id_q;
        if (ovf_q) begin
          resp_ok_d  = 1'b0;
          resp_err_d = 1'b1;
          state_d    = S_RESP;
        end else if (count_q == '0) begin
          resp_ok_d  = 1'b1;
          resp_err_d = 1'b0;
          state_d    = S_RESP;
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (CNT_W'(ptr_q) == count_q - CNT_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        resp_ok_d  = chk_result;
        resp_err_d = 1'b0;
        resp_id_d  = grant_id_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = 2'b00;
    if (state_d == S_LOAD) req_ready_d = grant_id_d ? 2'b10 : 2'b01;
    chk_in_d     = (state_d == S_PLAY) ? mem_q[ptr_d] : 8'h00;
    chk_reset_d  = !((state_d == S_PLAY) || (state_d == S_SAMPLE));
    resp_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      req_ready_q  <= 2'b00;
      chk_in_q     <= 8'h00;
      chk_reset_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      req_ready_q  <= req_ready_d;
      chk_in_q     <= chk_in_d;
      chk_reset_q  <= chk_reset_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_ok_q    <= resp_ok_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Message buffer; contents are meaningless after reset so it carries none.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem_q[count_q[ADDR_W-1:0]] <= in_data_c;
  end

  assign req_ready  = req_ready_q;
  assign chk_in     = chk_in_q;
  assign chk_reset  = chk_reset_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_ok    = resp_ok_q;
  assign resp_err   = resp_err_q;

endmodule

// File: doc/block_check_sched.md
# block_check_sched

Round-robin scheduler that shares one `BlockChecker` instance between two character-stream requesters.
- Each requester submits a NUL-terminated message over a valid/ready handshake.
- The message is buffered, then replayed one character per cycle into a freshly cleared checker.
- The checker's `result` is sampled and returned as a tagged response.
- Sits between the text sources and the checker; the checker's `clk`, `reset`, `in` and `result` connect only to this block.

## Interface
- `ADDR_W`, default 4: buffer address width. `DEPTH = 1<<ADDR_W` characters.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `req_valid` input 2: per-requester character valid. Bit i belongs to requester i.
- `req_data` input 2x8 (`req_data0`, `req_data1`): per-requester character. 8'h00 terminates the message.
- `req_ready` output 2: per-requester accept. At most one bit high.
- `chk_in` output 8: character to the checker's `in`.
- `chk_reset` output 1: to the checker's async active-high `reset`. Driven from a flop, never decoded combinationally.
- `chk_result` input 1: checker's `result`.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: response consumer accept.
- `resp_id` output 1: requester the response belongs to.
- `resp_ok` output 1: 1 = blocks balanced (checker result 1).
- `resp_err` output 1: 1 = message exceeded DEPTH and was not checked.

## Operation
- States: IDLE, LOAD, CLEAR, PLAY, SAMPLE, RESP. Internal registers:
  - `grant_id`
  - `last_grant` (reset 1, so requester 0 wins first)
  - `count` (ADDR_W+1 bits)
  - `ptr`
  - `ovf`
  - buffer DEPTH x 8
- IDLE, arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the one != `last_grant`.
  - On grant: `grant_id` <= winner, `count` <= 0, `ovf` <= 0, go to LOAD.
  - `req_ready` = 0 in IDLE.
- LOAD:
  - `req_ready[grant_id]` = 1; the other bit = 0.
  - Each accepted non-NUL character: if `count` < DEPTH, write it to `buf[count]` and increment `count`; otherwise discard it and set `ovf`.
  - Accepted NUL is not stored; go to CLEAR.
  - Requester bubbles (valid low) are allowed and simply wait.
- CLEAR (1 cycle): `ptr` <= 0. Next state:
  - `ovf`: RESP with `resp_ok` = 0, `resp_err` = 1.
  - else `count` == 0: RESP with `resp_ok` = 1, `resp_err` = 0.
  - else: PLAY.
- PLAY:
  - `chk_in` = `buf[ptr]`, `ptr` increments each cycle.
  - After `count` cycles go to SAMPLE.
- SAMPLE (1 cycle):
  - `resp_ok` <= `chk_result`, `resp_err` <= 0, `resp_id` <= `grant_id`.
  - Go to RESP.
- RESP:
  - `resp_valid` = 1; `resp_id`, `resp_ok` and `resp_err` are held stable.
  - On `resp_valid` && `resp_ready`: `last_grant` <= `grant_id`, go to IDLE.
- `chk_reset` = 1 in every cycle whose state is not PLAY or SAMPLE, so the checker is cleared before each replay.
- `chk_in` = 8'h00 outside PLAY.
- Characters are passed through unmodified, including spaces and case. Balancing semantics belong to the checker.
- Only one message is in flight. The non-granted requester sees `req_ready` = 0 until the next IDLE arbitration.
- Reset (`reset` = 0 at an edge):
  - Next cycle: state IDLE, `last_grant` = 1, `req_ready` = 0, `resp_valid` = 0, `resp_id` = 0, `resp_ok` = 0, `resp_err` = 0, `chk_in` = 0, `chk_reset` = 1.
  - Buffer contents are don't-care.
  - Reset mid-LOAD, PLAY or RESP drops the message and its response silently.

## Timing
- Let L be the cycle the NUL is accepted and N = `count`.
  - CLEAR at L+1.
  - PLAY at L+2 .. L+N+1; character k is on `chk_in` in cycle L+2+k.
  - SAMPLE at L+N+2.
  - `resp_valid` first high at L+N+3.
- Empty or overflow message: `resp_valid` first high at L+2. No PLAY cycles; `chk_reset` stays 1.
- `chk_reset` is low exactly in cycles L+2 .. L+N+2.
- `chk_result` is sampled in cycle L+N+2, after the checker has registered the last character at the end of cycle L+N+1.
- Grant takes 1 cycle: `req_valid` seen in IDLE at cycle G means `req_ready` is high from G+1.
- After the response handshake at cycle H, IDLE is at H+1 and the earliest next `req_ready` is at H+2.
- Exactly DEPTH characters: not overflow. DEPTH+1 characters: overflow.
- `resp_ready` held low: RESP persists indefinitely with outputs stable.

## Test plan
- Requester 0 sends "begin end" + NUL, `resp_ready` = 1. Expect `resp_valid` at L+12 with `resp_id` = 0, `resp_ok` = 1, `resp_err` = 0. Expect `chk_in` = 'b','e','g','i','n',' ','e','n','d' on L+2..L+10.
- Requester 1 sends "END bEgIn" + NUL. Expect `resp_id` = 1, `resp_ok` = 0, `resp_err` = 0.
- Both requesters valid continuously from reset release, each sending "begin end".
  - Expected grant order: 0, 1, 0, 1.
  - `req_ready` is never high for both requesters at once.
  - The losing requester's characters are not consumed.
- DEPTH = 16: send 17 × 'a' + NUL.
  - All 18 characters are accepted.
  - `resp_err` = 1 and `resp_ok` = 0 at L+2.
  - `chk_reset` stays 1 throughout.
- NUL-only message: `resp_ok` = 1, `resp_err` = 0 at L+2. Then hold `resp_ready` = 0 for 3 cycles: outputs stay stable, with the handshake completing on the 4th cycle.
- Assert `reset` = 0 for one cycle during PLAY of "begin".
  - Next cycle: IDLE, `chk_reset` = 1, `resp_valid` = 0.
  - A following "begin end" from requester 0 returns `resp_ok` = 1.
